mem_response_unit: RTL
======================

Name: mem_response_unit

Overview:
- Responder side of the CPU memory request handshake.
- Accepts instruction fetch requests (iREN) and data requests (dREN/dWEN) from the datapath request logic, and arbitrates them onto a single RAM port with variable latency.
- Returns one-cycle ihit/dhit pulses with registered load data.
- Requesters hold their request level-high until the hit, then drop it one cycle later.

Parameters:
- ADDR_W, 32, address width of the requester and RAM ports.
- DATA_W, 32, data width of the load and store paths.
- TIMEOUT, 64, maximum cycles one RAM access may wait for ram_ready before it is abandoned.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request (level).
- iaddr  in  ADDR_W  fetch address.
- ihit  out  1  one-cycle fetch-complete pulse.
- iload  out  DATA_W  fetched word; valid while ihit=1.
- dREN  in  1  data read request (level).
- dWEN  in  1  data write request (level).
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dhit  out  1  one-cycle data-complete pulse.
- dload  out  DATA_W  read word; valid while dhit=1.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data; valid with ram_ready.
- ram_ready  in  1  RAM access complete this cycle.
- err  out  1  sticky protocol/timeout error flag.

Behaviour:
- Reset: RST=1 at a rising edge forces the following, overriding any access in flight:
  - state=IDLE;
  - ihit, dhit, ramREN, ramWEN, err = 0;
  - iload, dload, ramaddr, ramstore = 0;
  - last_grant=I;
  - timeout counter=0.
- States: IDLE, IACC, DACC, IDONE, DDONE.
- IDLE, grant decision:
  - data pending (dREN|dWEN) and iREN=0 -> DACC.
  - iREN=1 and no data pending -> IACC.
  - Both pending -> round-robin: grant the side not equal to last_grant.
  - On entry to an access state: latch address, store data and access type; set last_grant; clear the counter.
- IACC / DACC:
  - ramREN/ramWEN/ramaddr/ramstore are driven from latched values (registered), valid from the first cycle in the state.
  - Counter increments each cycle ram_ready=0.
- ram_ready=1 in IACC:
  - If iREN is still 1: iload<=ramload, go to IDONE.
  - Else (flushed): go to IDLE with no hit.
- ram_ready=1 in DACC:
  - Reads capture dload<=ramload.
  - If the latched request type is still asserted: go to DDONE; else go to IDLE with no hit.
- Writes are never aborted: a write launched to RAM stays on the port until ram_ready, even if dWEN drops.
- Hit timing:
  - ramREN/ramWEN deassert in the cycle after ram_ready.
  - IDONE/DDONE last exactly one cycle, with ihit/dhit=1, then -> IDLE.
  - Requester drops the request during that cycle, so IDLE never re-grants a completed request.
- Minimum latency: request sampled at edge 0; RAM strobes active cycle 1; with ram_ready=1 in cycle 1, hit is high in cycle 2.
- Back-to-back: a new request can be granted on the edge leaving IDLE, so there is one IDLE cycle between accesses.
- dREN=1 and dWEN=1 together at grant: treated as a write; err<=1.
- Timeout: counter reaches TIMEOUT in IACC/DACC:
  - err<=1;
  - strobes deasserted;
  - -> IDLE with no hit.
  - The requester remains stalled; err stays set until reset.
- ihit and dhit are never high in the same cycle. At most one RAM access is outstanding.
- Address, data and type are latched at grant. Requester changes during an access are ignored, except the drop of the request level, which suppresses the hit.

Test Plan:
- Single read: iREN=1, iaddr=0x40, ram_ready=1 in the first access cycle, ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 in cycle 1; ihit=1, iload=0xDEADBEEF in cycle 2; ihit=0 in cycle 3.
- Contention: iREN and dREN high together from reset, ram_ready tied 1 -> dhit served first, then ihit; alternation continues while both are held.
- Flushed write: dWEN=1, daddr=0x80, dstore=0x1234, ram_ready delayed 5 cycles, dWEN dropped after 2 cycles -> ramWEN stays 1 until ram_ready, dhit never pulses, FSM returns to IDLE.
- Timeout: TIMEOUT=4, dREN=1, ram_ready held 0 -> strobes drop after 4 access cycles, err=1 sticky, no dhit; RST=1 clears err.
- Reset mid-access: RST asserted in DACC -> next cycle all outputs 0 and state IDLE; a subsequent iREN is served normally.
- Illegal request: dREN=dWEN=1 -> ramWEN=1, ramREN=0, err=1, dhit still pulses on ram_ready.

Source files
------------

// File: rtl/mem_response_unit.sv
// Responder for the CPU instruction/data request handshake: arbitrates fetches and
// data accesses onto one variable-latency RAM port and returns one-cycle hit pulses.
//
// state | meaning
// IDLE  | no access outstanding, grant decision made here
// IACC  | instruction fetch on the RAM port
// DACC  | data read or write on the RAM port
// IDONE | ihit pulse cycle
// DDONE | dhit pulse cycle
module mem_response_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, IACC, DACC, IDONE, DDONE} state_t;

    state_t           state;
    logic             last_grant;   // 1 = data side was granted last
    logic             acc_wr;
    logic [CNT_W-1:0] cnt;
    logic             d_pend;
    logic             grant_d;
    logic             d_still;

    always_comb begin
        d_pend  = dREN | dWEN;
        grant_d = d_pend & (~iREN | ~last_grant);
        d_still = acc_wr ? dWEN : dREN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            ihit       <= 1'b0;
            dhit       <= 1'b0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            err        <= 1'b0;
            iload      <= '0;
            dload      <= '0;
            ramaddr    <= '0;
            ramstore   <= '0;
            last_grant <= 1'b0;
            acc_wr     <= 1'b0;
            cnt        <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= DACC;
                        last_grant <= 1'b1;
                        acc_wr     <= dWEN;
                        ramWEN     <= dWEN;
                        ramREN     <= ~dWEN;
                        ramaddr    <= daddr;
                        ramstore   <= dstore;
                        cnt        <= '0;
                        if (dREN && dWEN) err <= 1'b1;
                    end else if (iREN) begin
                        state      <= IACC;
                        last_grant <= 1'b0;
                        acc_wr     <= 1'b0;
                        ramREN     <= 1'b1;
                        ramWEN     <= 1'b0;
                        ramaddr    <= iaddr;
                        cnt        <= '0;
                    end
                end
                IACC: begin
                    if (ram_ready) begin
                        ramREN <= 1'b0;
                        if (iREN) begin
                            iload <= ramload;
                            ihit  <= 1'b1;
                            state <= IDONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        err    <= 1'b1;
                        ramREN <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DACC: begin
                    if (ram_ready) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (!acc_wr) dload <= ramload;
                        if (d_still) begin
                            dhit  <= 1'b1;
                            state <= DDONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        err    <= 1'b1;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDONE, DDONE: state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

endmodule
